// File: rtl/dm_access_pkg.sv
// rtl/dm_access_pkg.sv - shared encodings for the data-memory access controller
// Contents: op encodings, exception codes, controller state encoding,
//           is_load/is_store classification helpers.
package dm_access_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LW   = 4'd1,
        OP_LH   = 4'd2,
        OP_LHU  = 4'd3,
        OP_LB   = 4'd4,
        OP_LBU  = 4'd5,
        OP_SW   = 4'd6,
        OP_SH   = 4'd7,
        OP_SB   = 4'd8
    } op_e;

    localparam logic [1:0] EXC_NONE  = 2'd0;
    localparam logic [1:0] EXC_ADEL  = 2'd1;
    localparam logic [1:0] EXC_ADES  = 2'd2;
    localparam logic [1:0] EXC_BUSTO = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    function automatic logic is_load(input logic [3:0] op);
        return (op >= OP_LW) && (op <= OP_LBU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SW) && (op <= OP_SB);
    endfunction

endpackage

// File: rtl/store_lane_gen.sv
// rtl/store_lane_gen.sv - alignment check, byte enables and store lane replication
// Ports: op[3:0], addr_lo[1:0], wdata[31:0] in;
//        be[3:0], lane_data[31:0], misaligned out (all combinational).
module store_lane_gen
    import dm_access_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] lane_data,
    output logic        misaligned
);

    always_comb begin
        be         = 4'b0000;
        lane_data  = 32'h0;
        misaligned = 1'b0;
        case (op)
            OP_LW: begin
                be         = 4'b1111;
                misaligned = (addr_lo != 2'b00);
            end
            OP_LH, OP_LHU: begin
                be         = 4'b1111;
                misaligned = addr_lo[0];
            end
            OP_LB, OP_LBU: begin
                be = 4'b1111;
            end
            OP_SW: begin
                be         = 4'b1111;
                lane_data  = wdata;
                misaligned = (addr_lo != 2'b00);
            end
            OP_SH: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_data  = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
            end
            OP_SB: begin
                be        = 4'b0001 << addr_lo;
                lane_data = {4{wdata[7:0]}};
            end
            default: begin
                be = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// rtl/dm_access_ctrl.sv - MEM-stage load/store sequencer for a variable-latency data bus
// Ports: clk, reset (sync, active-low); pipeline side req/op/addr/wdata in,
//        stall/done/rdata/addr_lo/exc/exc_code out; bus side bus_req/bus_we/
//        bus_be/bus_addr/bus_wdata out, bus_ack/bus_rdata in.
module dm_access_ctrl
    import dm_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [3:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic [1:0]  addr_lo,
    output logic        exc,
    output logic [1:0]  exc_code,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] lane_q, lane_d;
    logic [7:0]  wdog_q, wdog_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [1:0]  exc_code_q, exc_code_d;

    logic [3:0]  gen_be;
    logic [31:0] gen_lane;
    logic        gen_misaligned;
    logic        op_valid;
    logic        busy;

    store_lane_gen u_lane (
        .op         (op),
        .addr_lo    (addr[1:0]),
        .wdata      (wdata),
        .be         (gen_be),
        .lane_data  (gen_lane),
        .misaligned (gen_misaligned)
    );

    assign op_valid = is_load(op) || is_store(op);
    assign busy     = (state_q == ST_BUSY);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        be_d       = be_q;
        lane_d     = lane_q;
        wdog_d     = wdog_q;
        rdata_d    = rdata_q;
        addr_lo_d  = addr_lo_q;
        exc_code_d = exc_code_q;
        case (state_q)
            ST_IDLE: begin
                if (req && op_valid) begin
                    if (gen_misaligned) begin
                        state_d    = ST_ERR;
                        exc_code_d = is_store(op) ? EXC_ADES : EXC_ADEL;
                    end else begin
                        state_d = ST_BUSY;
                        op_d    = op;
                        addr_d  = addr;
                        be_d    = gen_be;
                        lane_d  = gen_lane;
                        wdog_d  = 8'd0;
                    end
                end
            end
            ST_BUSY: begin
                // An ack in the final watchdog cycle still completes normally.
                if (bus_ack) begin
                    state_d   = ST_DONE;
                    rdata_d   = is_load(op_q) ? bus_rdata : 32'h0;
                    addr_lo_d = addr_q[1:0];
                    wdog_d    = 8'd0;
                end else if (wdog_q == WDOG_LAST) begin
                    state_d    = ST_ERR;
                    exc_code_d = EXC_BUSTO;
                    wdog_d     = 8'd0;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            op_q       <= 4'd0;
            addr_q     <= 32'h0;
            be_q       <= 4'd0;
            lane_q     <= 32'h0;
            wdog_q     <= 8'd0;
            rdata_q    <= 32'h0;
            addr_lo_q  <= 2'd0;
            exc_code_q <= EXC_NONE;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            lane_q     <= lane_d;
            wdog_q     <= wdog_d;
            rdata_q    <= rdata_d;
            addr_lo_q  <= addr_lo_d;
            exc_code_q <= exc_code_d;
        end
    end

    // Stall must rise in the accepting IDLE cycle itself, so it is partly combinational.
    assign stall     = busy || ((state_q == ST_IDLE) && req && op_valid);
    assign done      = (state_q == ST_DONE);
    assign exc       = (state_q == ST_ERR);
    assign exc_code  = exc ? exc_code_q : EXC_NONE;
    assign rdata     = rdata_q;
    assign addr_lo   = addr_lo_q;
    assign bus_req   = busy;
    assign bus_we    = busy && is_store(op_q);
    assign bus_be    = busy ? be_q : 4'b0000;
    assign bus_addr  = busy ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus_wdata = busy ? lane_q : 32'h0;

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Sequences every MEM-stage load/store onto a single-ported, variable-latency data-memory bus.
- Checks alignment and generates byte enables and replicated store lanes.
- Holds the pipeline stalled until the bus acknowledges, then presents the raw read word and the low address bits to the existing load-extension stage.
- Aborts hung accesses with a watchdog timeout.

Parameters:
- TIMEOUT, 16, number of BUSY cycles without bus_ack before the access is aborted with a bus-error exception (range 1..255).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clk edge)
- req  in  1  MEM stage presents a valid memory op; held stable while stall=1
- op  in  4  0 NONE, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB; others are treated as NONE
- addr  in  32  byte address
- wdata  in  32  store data (right-justified)
- stall  out  1  freeze IF..MEM stages
- done  out  1  one-cycle pulse: access complete, rdata/addr_lo valid
- rdata  out  32  raw memory word for loads (0 for stores)
- addr_lo  out  2  latched addr[1:0], for the extender
- exc  out  1  one-cycle exception pulse
- exc_code  out  2  0 none, 1 AdEL, 2 AdES, 3 bus timeout
- bus_req  out  1  access request
- bus_we  out  1  write strobe
- bus_be  out  4  byte enables
- bus_addr  out  32  {addr[31:2],2'b00}
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  access complete (may arrive in the first cycle bus_req is high)
- bus_rdata  in  32  read word, valid with bus_ack

Behaviour:
- Reset: state IDLE. All outputs are 0: stall, done, rdata, addr_lo, exc, exc_code, bus_req, bus_we, bus_be, bus_addr, bus_wdata. Watchdog counter is 0.
- States: IDLE, BUSY, DONE, ERR.
- Alignment rules:
  - Word ops fault if addr[1:0]!=0.
  - Halfword ops fault if addr[0]!=0.
  - Bytes never fault.
- IDLE, req=1, op!=NONE, misaligned:
  - Next state is ERR. No bus access.
  - stall=1 combinationally in this cycle.
- IDLE, req=1, op!=NONE, aligned:
  - Latch op, addr, wdata; next state is BUSY.
  - stall=1 combinationally.
- IDLE with req=0 or op=NONE: stall=0; state stays IDLE.
- BUSY:
  - bus_req=1 and stall=1. All bus_* outputs come from latched registers and are stable for the whole access.
  - Watchdog increments each BUSY cycle.
  - bus_ack=1: capture bus_rdata into rdata (loads only), next state DONE, watchdog cleared.
  - If the watchdog reaches TIMEOUT-1 and bus_ack=0 in that cycle, next state is ERR with code 3; bus_req is dropped.
  - bus_ack wins over timeout when both occur in the same cycle.
- DONE:
  - done=1, stall=0; rdata and addr_lo are valid.
  - Next state is IDLE. A new req is only accepted from IDLE, so back-to-back ops are spaced by at least 3 cycles.
- ERR:
  - exc=1, stall=0.
  - exc_code = 1 for misaligned load, 2 for misaligned store, 3 for timeout.
  - Next state is IDLE.
- Outside their pulse cycle, exc, exc_code and done are 0. rdata and addr_lo hold their last values.
- Store lanes and byte enables:
  - SW: be=1111, data=wdata.
  - SH: data={wdata[15:0],wdata[15:0]}; be=1100 if addr[1], else 0011.
  - SB: data={4{wdata[7:0]}}; be=0001<<addr[1:0].
  - Loads: be=1111, bus_we=0, bus_wdata=0.
- bus_ack outside BUSY is ignored.
- Reset while BUSY: bus_req is 0 after the edge and the transaction is abandoned. The memory side must tolerate a dropped request.

Decomposition:
- Package dm_access_pkg holds:
  - op encodings (OP_NONE..OP_SB)
  - exc codes (EXC_NONE, EXC_ADEL, EXC_ADES, EXC_BUSTO)
  - the state encoding
  - helper constants is_load/is_store
- One combinational sub-module, store_lane_gen:
  - inputs: op, addr[1:0], wdata
  - outputs: be[3:0], lane_data[31:0], misaligned
- The controller FSM, latches and watchdog stay in dm_access_ctrl.

Test Plan:
- LW addr=0x0000_0010, bus_ack on 1st BUSY cycle, bus_rdata=0xDEADBEEF -> bus_addr=0x10, be=1111, we=0; stall high 2 cycles; done pulse with rdata=0xDEADBEEF, addr_lo=0.
- SB addr=0x0000_0023, wdata=0x000000A5, ack after 3 cycles -> be=1000, bus_wdata=0xA5A5A5A5, bus_addr=0x20, we=1; stall 4 cycles, then done.
- SH addr=0x0000_0042 -> be=1100, bus_wdata={wdata[15:0]}x2; LH addr=0x0000_0041 -> exc=1, exc_code=1, bus_req never asserted.
- SW addr=0x0000_0006 -> exc_code=2, no bus activity; next cycle is IDLE with stall=0.
- TIMEOUT=4, LW with no ack -> bus_req high exactly 4 cycles, then exc_code=3 pulse; done never asserted.
- reset=0 asserted during BUSY of LBU -> next cycle bus_req=0, all outputs 0, state IDLE; a later ack is ignored.
